bcd_bin_conv: RTL

Parametrised, bidirectional BCD/binary converter with a start/done handshake. It converts packed BCD to binary (multiply-accumulate, one digit per cycle) or binary to packed BCD (shift-add-3, one bit per cycle). It flags invalid BCD digits and range overflow. It sits between the keypad/display BCD datapaths and the binary arithmetic blocks, and replaces free-running fixed-width conversion with an explicitly requested, handshaked one.

---
 rtl/bcd_bin_conv.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bcd_bin_conv.sv
// Handshaked BCD <-> binary converter: multiply-accumulate for BCD->binary,
// shift-add-3 (double dabble) for binary->BCD, with invalid-digit and overflow flags.
module bcd_bin_conv #(
   parameter int DIGITS = 7,
   parameter int BIN_W  = 24
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                mode,
   input  logic [4*DIGITS-1:0] din_bcd,
   input  logic [BIN_W-1:0]    din_bin,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [BIN_W-1:0]    dout_bin,
   output logic [4*DIGITS-1:0] dout_bcd
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int ACC_W = BIN_W + 4;
   localparam int N_MAX = (DIGITS > BIN_W) ? DIGITS : BIN_W;
   localparam int CNT_W = $clog2(N_MAX + 1);

   typedef enum logic [1:0] {IDLE, CONV, FIN} state_t;

   state_t             state_reg, state_next;
   logic               mode_reg, mode_next;
   logic [ACC_W-1:0]   acc_reg, acc_next;
   logic [BCD_W-1:0]   bcd_reg, bcd_next;
   logic [BIN_W-1:0]   bin_reg, bin_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               sticky_reg, sticky_next;
   logic               done_reg, done_next;
   logic               err_reg, err_next;
   logic [BIN_W-1:0]   dout_bin_reg, dout_bin_next;
   logic [BCD_W-1:0]   dout_bcd_reg, dout_bcd_next;

   // bcd_reg doubles as the operand shifter in mode 0 and the result builder in mode 1.
   logic [3:0]         digit;
   logic [ACC_W-1:0]   acc_mac;
   logic               acc_ovf;
   logic [BCD_W-1:0]   bcd_adj;

   assign digit   = bcd_reg[BCD_W-1 -: 4];
   assign acc_mac = (acc_reg << 3) + (acc_reg << 1) + {{(ACC_W-4){1'b0}}, digit};
   assign acc_ovf = |acc_mac[ACC_W-1:BIN_W];

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                     bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
      end
   endgenerate

   always_comb begin
      state_next    = state_reg;
      mode_next     = mode_reg;
      acc_next      = acc_reg;
      bcd_next      = bcd_reg;
      bin_next      = bin_reg;
      cnt_next      = cnt_reg;
      sticky_next   = sticky_reg;
      done_next     = 1'b0;
      err_next      = err_reg;
      dout_bin_next = dout_bin_reg;
      dout_bcd_next = dout_bcd_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               mode_next   = mode;
               acc_next    = '0;
               sticky_next = 1'b0;
               if (mode) begin
                  bcd_next = '0;
                  bin_next = din_bin;
                  cnt_next = CNT_W'(BIN_W);
               end else begin
                  bcd_next = din_bcd;
                  cnt_next = CNT_W'(DIGITS);
               end
               state_next = CONV;
            end
         end
         CONV: begin
            if (!mode_reg) begin
               bcd_next = bcd_reg << 4;
               if (digit > 4'd9 || acc_ovf) sticky_next = 1'b1;
               acc_next = {4'b0, acc_mac[BIN_W-1:0]};
            end else begin
               {bcd_next, bin_next} = {bcd_adj[BCD_W-2:0], bin_reg, 1'b0};
               if (bcd_adj[BCD_W-1]) sticky_next = 1'b1;
            end
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) state_next = FIN;
         end
         FIN: begin
            done_next = 1'b1;
            err_next  = sticky_reg;
            if (!mode_reg) dout_bin_next = sticky_reg ? '0 : acc_reg[BIN_W-1:0];
            else           dout_bcd_next = sticky_reg ? '0 : bcd_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         mode_reg     <= 1'b0;
         acc_reg      <= '0;
         bcd_reg      <= '0;
         bin_reg      <= '0;
         cnt_reg      <= '0;
         sticky_reg   <= 1'b0;
         done_reg     <= 1'b0;
         err_reg      <= 1'b0;
         dout_bin_reg <= '0;
         dout_bcd_reg <= '0;
      end else begin
         state_reg    <= state_next;
         mode_reg     <= mode_next;
         acc_reg      <= acc_next;
         bcd_reg      <= bcd_next;
         bin_reg      <= bin_next;
         cnt_reg      <= cnt_next;
         sticky_reg   <= sticky_next;
         done_reg     <= done_next;
         err_reg      <= err_next;
         dout_bin_reg <= dout_bin_next;
         dout_bcd_reg <= dout_bcd_next;
      end
   end

   assign busy     = (state_reg != IDLE);
   assign done     = done_reg;
   assign err      = err_reg;
   assign dout_bin = dout_bin_reg;
   assign dout_bcd = dout_bcd_reg;

endmodule
